// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scan_pkg
//  Description : Shared types and constants for the scanner TX shot path.
//  Revision    : 1.0  initial release
// ============================================================================
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_BURST    = 2'd2,
    ST_LISTEN   = 2'd3
  } shot_state_t;

  typedef logic [15:0] tx_word_t;

  localparam tx_word_t c_MARKER_DEF = 16'hBC50;

  // Zero selects the default period; anything shorter than a full shot is raised.
  function automatic logic [15:0] eff_period(input logic [15:0] cfg,
                                             input logic [15:0] pdef,
                                             input logic [15:0] pmin);
    logic [15:0] p;
    p = (cfg == 16'd0) ? pdef : cfg;
    return (p < pmin) ? pmin : p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/laser_shot_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : laser_shot_tx_if
//  Description : Control/TX bundle between scan control, shot sequencer, XCVR.
//  Revision    : 1.0  initial release
// ============================================================================
interface laser_shot_tx_if;
  import scan_pkg::*;

  logic        enable;
  logic [15:0] period_cfg;
  logic        zero_pulse;
  logic        tx_ready;
  logic        send_en;
  tx_word_t    tx_datain;
  logic        tx_ctrl;
  logic        zero_flag;
  logic        busy;
  logic [15:0] shot_id;
  logic [15:0] skip_cnt;

  modport master (
    output enable, period_cfg, zero_pulse, tx_ready,
    input  send_en, tx_datain, tx_ctrl, zero_flag, busy, shot_id, skip_cnt
  );

  modport slave (
    input  enable, period_cfg, zero_pulse, tx_ready,
    output send_en, tx_datain, tx_ctrl, zero_flag, busy, shot_id, skip_cnt
  );
endinterface
`default_nettype wire

// File: rtl/laser_shot_tx_period_timer.sv
`default_nettype none
// ============================================================================
//  Module      : period_timer
//  Description : Free-running shot period counter, period latched per run.
//  Revision    : 1.0  initial release
// ============================================================================
module period_timer (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        i_hold,
  input  wire logic [15:0] i_period,
  output logic             o_expire
);

  logic [15:0] r_cnt;
  logic [15:0] r_per;

  // The period is captured on the first count of each run (after reset, hold or expiry).
  assign o_expire = !i_hold && (r_cnt != 16'd0) && (r_cnt == r_per - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 16'd0;
      r_per <= 16'd0;
    end else begin
      if (r_cnt == 16'd0) r_per <= i_period;
      if (i_hold || o_expire) r_cnt <= 16'd0;
      else                    r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/laser_shot_tx.sv
`default_nettype none
// ============================================================================
//  Module      : laser_shot_tx
//  Description : Periodic laser shot sequencer driving the transceiver TX path.
//  Revision    : 1.0  initial release
// ============================================================================
module laser_shot_tx
  import scan_pkg::*;
#(
  parameter int       PERIOD_DEF = 2000,
  parameter int       BURST_LEN  = 16,
  parameter int       LISTEN_LEN = 1200,
  parameter tx_word_t MARKER     = c_MARKER_DEF
) (
  input  wire logic        clk,
  input  wire logic        rst,
  laser_shot_tx_if.slave   bus
);

  localparam logic [15:0] c_P_DEF       = 16'(PERIOD_DEF);
  localparam logic [15:0] c_P_MIN       = 16'(BURST_LEN + LISTEN_LEN + 2);
  localparam logic [15:0] c_BURST_LAST  = 16'(BURST_LEN - 1);
  localparam logic [15:0] c_LISTEN_LAST = 16'(LISTEN_LEN - 1);

  shot_state_t r_state, w_state;
  logic [15:0] r_idx, w_idx;
  logic        r_send, w_send;
  tx_word_t    r_data, w_data;
  logic        r_ctrl, w_ctrl;
  logic        r_zflag, w_zflag;
  logic        r_pend, w_pend;
  logic [15:0] r_shot, w_shot;
  logic [15:0] r_skip, w_skip;
  logic        w_expire;

  period_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_hold   (!bus.enable),
    .i_period (eff_period(bus.period_cfg, c_P_DEF, c_P_MIN)),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_send  = 1'b0;
    w_data  = '0;
    w_ctrl  = 1'b0;
    w_zflag = r_zflag;
    w_pend  = r_pend | bus.zero_pulse;
    w_shot  = r_shot;
    w_skip  = r_skip;
    unique case (r_state)
      ST_IDLE: begin
        w_zflag = 1'b0;
        if (w_expire) w_state = bus.tx_ready ? ST_BURST : ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (!bus.enable) begin
          w_state = ST_IDLE;
          w_zflag = 1'b0;
        end else if (bus.tx_ready) begin
          w_state = ST_BURST;
        end else if (w_expire && r_skip != 16'hFFFF) begin
          w_skip = r_skip + 16'd1;
        end
      end
      ST_BURST: begin
        if (r_idx == c_BURST_LAST) begin
          w_state = ST_LISTEN;
          w_idx   = '0;
        end else begin
          w_idx  = r_idx + 16'd1;
          w_send = 1'b1;
          w_data = r_shot + r_idx + 16'd1;
        end
      end
      ST_LISTEN: begin
        if (r_idx == c_LISTEN_LAST) begin
          w_state = ST_IDLE;
          w_shot  = r_shot + 16'd1;
          w_zflag = 1'b0;
        end else begin
          w_idx = r_idx + 16'd1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
    // Burst entry: a pulse landing on this very cycle stays pending for the next shot.
    if (w_state == ST_BURST && r_state != ST_BURST) begin
      w_idx   = '0;
      w_send  = 1'b1;
      w_data  = MARKER;
      w_ctrl  = 1'b1;
      w_zflag = r_pend;
      w_pend  = bus.zero_pulse;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_send  <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= 1'b0;
      r_zflag <= 1'b0;
      r_pend  <= 1'b0;
      r_shot  <= '0;
      r_skip  <= '0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_send  <= w_send;
      r_data  <= w_data;
      r_ctrl  <= w_ctrl;
      r_zflag <= w_zflag;
      r_pend  <= w_pend;
      r_shot  <= w_shot;
      r_skip  <= w_skip;
    end
  end

  assign bus.send_en   = r_send;
  assign bus.tx_datain = r_data;
  assign bus.tx_ctrl   = r_ctrl;
  assign bus.zero_flag = r_zflag;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.shot_id   = r_shot;
  assign bus.skip_cnt  = r_skip;

endmodule
`default_nettype wire

// File: tb/tb_laser_shot_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_laser_shot_tx
//  Description : Directed self-checking bench for laser_shot_tx.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_laser_shot_tx;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_err;

  laser_shot_tx_if u_if ();

  laser_shot_tx u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Cycle n is the clock period whose negedge is n negedges after reset release.
  task automatic tick();
    @(negedge clk);
    cyc++;
    u_if.zero_pulse = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic run_shot(input int exp_rise, input logic [15:0] exp_id,
                          input logic exp_zf, input int drop_at);
    int   wait_n;
    int   len;
    int   llen;
    logic bad;
    wait_n = 0;
    while (!u_if.send_en && wait_n < 5000) begin
      tick();
      wait_n++;
    end
    chk("rise_cyc", cyc, exp_rise);
    chk("word0", u_if.tx_datain, 32'h0000BC50);
    chk("ctrl0", u_if.tx_ctrl, 1);
    chk("zflag", u_if.zero_flag, exp_zf);
    chk("busy", u_if.busy, 1);
    len = 0;
    bad = 1'b0;
    while (u_if.send_en && len < 64) begin
      if (len > 0)
        chk("wordk", {u_if.tx_ctrl, u_if.tx_datain}, {1'b0, 16'(exp_id + len)});
      if (u_if.zero_flag !== exp_zf) bad = 1'b1;
      if (len == drop_at) u_if.enable = 1'b0;
      tick();
      len++;
    end
    chk("burst_len", len, 16);
    llen = 0;
    while (u_if.busy && llen < 5000) begin
      if (u_if.send_en || u_if.tx_datain != 16'd0 || u_if.zero_flag !== exp_zf) bad = 1'b1;
      tick();
      llen++;
    end
    chk("listen_len", llen, 1200);
    chk("shot_quiet", bad, 0);
    chk("shot_id", u_if.shot_id, 32'(16'(exp_id + 16'd1)));
    chk("zflag_clr", u_if.zero_flag, 0);
  endtask

  task automatic expect_quiet_to(input string tag, input int target);
    logic seen;
    seen = 1'b0;
    while (cyc < target) begin
      if (u_if.send_en) seen = 1'b1;
      tick();
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    rst   = 1'b1;
    u_if.enable     = 1'b1;
    u_if.period_cfg = 16'd0;
    u_if.zero_pulse = 1'b0;
    u_if.tx_ready   = 1'b1;

    // Default period, three shots
    do_reset();
    chk("rst_send", u_if.send_en, 0);
    chk("rst_data", u_if.tx_datain, 0);
    chk("rst_ctrl", u_if.tx_ctrl, 0);
    chk("rst_zf", u_if.zero_flag, 0);
    chk("rst_busy", u_if.busy, 0);
    chk("rst_shot", u_if.shot_id, 0);
    chk("rst_skip", u_if.skip_cnt, 0);
    run_shot(2000, 16'd0, 1'b0, -1);
    run_shot(4000, 16'd1, 1'b0, -1);
    run_shot(6000, 16'd2, 1'b0, -1);

    // Short period is clamped to 16+1200+2
    u_if.period_cfg = 16'd100;
    do_reset();
    run_shot(1218, 16'd0, 1'b0, -1);
    run_shot(2436, 16'd1, 1'b0, -1);

    // Zero flag: pulse at 500 tags shot 1; pulse on burst entry tags the next shot
    u_if.period_cfg = 16'd0;
    do_reset();
    tick_to(500);
    u_if.zero_pulse = 1'b1;
    run_shot(2000, 16'd0, 1'b1, -1);
    run_shot(4000, 16'd1, 1'b0, -1);
    tick_to(6000);
    chk("entry_send", u_if.send_en, 1);
    u_if.zero_pulse = 1'b1;
    run_shot(6000, 16'd2, 1'b0, -1);
    run_shot(8000, 16'd3, 1'b1, -1);

    // tx_ready low for cycles 0..2499 with P=1218: one skip, delayed burst
    u_if.period_cfg = 16'd100;
    u_if.tx_ready   = 1'b0;
    do_reset();
    expect_quiet_to("no_send_wait", 1218);
    chk("wait_busy", u_if.busy, 1);
    expect_quiet_to("no_send_wait2", 2500);
    chk("skip_cnt", u_if.skip_cnt, 1);
    u_if.tx_ready = 1'b1;
    run_shot(2501, 16'd0, 1'b0, -1);
    expect_quiet_to("no_double", 4871);
    run_shot(4872, 16'd1, 1'b0, -1);
    chk("skip_hold", u_if.skip_cnt, 1);

    // enable dropped at burst word 5
    u_if.period_cfg = 16'd0;
    u_if.enable     = 1'b1;
    do_reset();
    run_shot(2000, 16'd0, 1'b0, 5);
    expect_quiet_to("no_send_dis", 6500);
    chk("idle_dis", u_if.busy, 0);

    // rst pulse at burst word 8
    u_if.enable = 1'b1;
    do_reset();
    tick_to(2008);
    chk("word8", u_if.tx_datain, 8);
    rst = 1'b1;
    tick();
    chk("mid_rst_send", u_if.send_en, 0);
    chk("mid_rst_data", u_if.tx_datain, 0);
    chk("mid_rst_ctrl", u_if.tx_ctrl, 0);
    chk("mid_rst_busy", u_if.busy, 0);
    chk("mid_rst_shot", u_if.shot_id, 0);
    rst = 1'b0;
    cyc = 0;
    run_shot(2000, 16'd0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/laser_shot_tx.md
# laser_shot_tx

Transmit-side shot sequencer for the single-line scanner. It fires periodic laser shots by driving `send_en` and a 16-bit marker burst into the high-speed transceiver TX path. It tags the first shot after each encoder index with `zero_flag`, then holds a listen window so the receive-side distance calculation can complete before the next shot. It sits between the scan/motor control logic and the transceiver, and is the producer of the `send_en`/`zero_flag` pair consumed by the distance calculation.

## Interface
- `PERIOD_DEF`, 2000: default shot period in clk cycles, used when `period_cfg == 0`.
- `BURST_LEN`, 16: number of cycles `send_en` is high per shot (≥2).
- `LISTEN_LEN`, 1200: number of cycles of the post-burst range window.
- `MARKER`, 16'hBC50: first burst word, sent as a control character.
- `clk` input 1: single clock domain.
- `rst` input 1: reset, synchronous, active-high.
- `enable` input 1: level; shots are allowed while high.
- `period_cfg` input 16: shot period in cycles; 0 selects `PERIOD_DEF`.
- `zero_pulse` input 1: 1-cycle encoder index strobe.
- `tx_ready` input 1: transceiver TX path is ready.
- `send_en` output 1: burst active.
- `tx_datain` output 16: TX word.
- `tx_ctrl` output 1: `tx_datain` is a control character.
- `zero_flag` output 1: current shot is the zero-position shot.
- `busy` output 1: FSM is not in IDLE.
- `shot_id` output 16: count of completed shots, wraps.
- `skip_cnt` output 16: count of shots dropped because `tx_ready` was low, saturates at FFFF.

## Operation
- FSM states: IDLE, WAIT_RDY, BURST, LISTEN.
- Effective period: `P = (period_cfg == 0) ? PERIOD_DEF : period_cfg`.
  - P is clamped to a minimum of `BURST_LEN + LISTEN_LEN + 2`.
  - P is sampled only at each expiry.
- Period counter:
  - Runs 0..P-1 while `enable` is high; expiry occurs at P-1.
  - Held at 0 while `enable` is low.
- IDLE:
  - On expiry with `tx_ready=1` → BURST.
  - On expiry with `tx_ready=0` → WAIT_RDY.
- WAIT_RDY:
  - `tx_ready=1` → BURST.
  - If the next expiry arrives first: `skip_cnt++`, stay in WAIT_RDY (no shot is queued twice).
- BURST:
  - `send_en=1` for exactly `BURST_LEN` cycles.
  - Word 0 is `MARKER` with `tx_ctrl=1`.
  - Words 1..`BURST_LEN`-1 are `shot_id + k` (k = word index, mod 2^16) with `tx_ctrl=0`.
  - Then → LISTEN.
- LISTEN:
  - `send_en=0`, `tx_datain=0`, for `LISTEN_LEN` cycles.
  - On exit `shot_id++`, then → IDLE.
- Zero flag:
  - `zero_pulse` sets a pending bit at any time.
  - Entering BURST copies pending to `zero_flag` and clears pending in the same cycle.
  - `zero_flag` holds through BURST and LISTEN and clears on return to IDLE.
  - A `zero_pulse` arriving on the cycle BURST is entered is kept pending for the next shot.
- `enable` falling mid-shot: the current BURST and LISTEN complete, then the FSM stays in IDLE. In WAIT_RDY, falling `enable` → IDLE with no skip counted.
- `tx_ready` dropping during BURST is ignored; the burst is never truncated.

## Timing
- All outputs are registered.
- Reset values: `send_en`=0, `tx_datain`=0, `tx_ctrl`=0, `zero_flag`=0, `busy`=0, `shot_id`=0, `skip_cnt`=0. Reset also clears the FSM, period counter and zero-pending bit.
- `rst` asserted mid-burst: `send_en` is low on the first cycle after the reset edge.
- Latency from expiry (with `tx_ready=1`) to `send_en` rising: 1 cycle.
- `tx_datain`, `tx_ctrl` and `zero_flag` are aligned with `send_en` on every cycle.
- Shot-to-shot spacing is exactly P cycles while `tx_ready` stays high.
- `busy` rises together with entry to WAIT_RDY or BURST, and falls on the IDLE cycle.

## Structure
- Shared package `scan_pkg` holds:
  - the state enum `shot_state_t`;
  - the `MARKER` default;
  - the TX word type `tx_word_t` (logic [15:0]).
- One sub-module: `period_timer`. It is a 16-bit counter with load-on-expiry of the clamped P, an `expire` strobe and a hold input.

## Test plan
- Default configuration, `enable=1`, `tx_ready=1`, 3 periods:
  - `send_en` rises at cycles 2000, 4000 and 6000 (±1 fixed latency);
  - each high for 16 cycles;
  - word 0 = 16'hBC50 with `tx_ctrl=1`;
  - `shot_id` = 3 at the end.
- `period_cfg=100`: P is clamped to 1218, so shots are spaced 1218 cycles apart.
- `zero_pulse` at cycle 500: `zero_flag` is high during shot 1 only. A pulse on the exact BURST-entry cycle flags the following shot.
- `tx_ready` held low for 2500 cycles from 0:
  - `skip_cnt=1`;
  - the burst starts 1 cycle after `tx_ready` rises;
  - no double burst.
- `enable` dropped at burst word 5: the burst still lasts 16 cycles and LISTEN completes; no further `send_en`.
- `rst` pulse at burst word 8: all outputs are 0 on the next cycle, and the first new shot occurs P cycles after reset release.
